// File: rtl/status_write_sequencer.sv
// Byte-serial command front end for the packed status register: collects a
// header plus a 24-bit little-endian payload and emits one write/set/clear strobe.
module status_write_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_in_valid,
  output logic        io_in_ready,
  input  logic [7:0]  io_in_bits,
  input  logic [23:0] io_status_rdata,
  output logic        io_wen,
  output logic [31:0] io_wdata,
  output logic        io_done,
  output logic        io_err
);

  typedef enum logic [2:0] {
    S_HDR    = 3'd0,
    S_B0     = 3'd1,
    S_B1     = 3'd2,
    S_B2     = 3'd3,
    S_COMMIT = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OP_WRITE   = 2'd0,
    OP_SET     = 2'd1,
    OP_CLEAR   = 2'd2,
    OP_ILLEGAL = 2'd3
  } op_e;

  typedef struct packed {
    op_e         op;
    logic [23:0] data;
  } cmd_t;

  // Reserved zero field of the packed status, bits [15:9].
  localparam logic [23:0] ZERO_FIELD = 24'h00FE00;

  state_e      state, state_nxt;
  cmd_t        cmd;
  logic        accept;
  logic [23:0] result;
  logic        legal;

  // ---------------------------------------------------------------------------
  // State and command registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state <= S_HDR;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd <= '0;
    end else if (accept) begin
      unique case (state)
        S_HDR:   cmd.op         <= op_e'(io_in_bits[1:0]);
        S_B0:    cmd.data[7:0]  <= io_in_bits;
        S_B1:    cmd.data[15:8] <= io_in_bits;
        S_B2:    cmd.data[23:16] <= io_in_bits;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stream handshake and next state
  // ---------------------------------------------------------------------------
  always_comb begin
    io_in_ready = (state != S_COMMIT);
    accept      = io_in_valid && io_in_ready;
    state_nxt   = state;
    unique case (state)
      S_HDR:    if (accept) state_nxt = S_B0;
      S_B0:     if (accept) state_nxt = S_B1;
      S_B1:     if (accept) state_nxt = S_B2;
      S_B2:     if (accept) state_nxt = S_COMMIT;
      S_COMMIT: state_nxt = S_HDR;
      default:  state_nxt = S_HDR;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read-modify-write datapath; rdata only matters in COMMIT
  // ---------------------------------------------------------------------------
  always_comb begin
    result = cmd.data;
    legal  = 1'b1;
    unique case (cmd.op)
      OP_WRITE:   result = cmd.data;
      OP_SET:     result = io_status_rdata | cmd.data;
      OP_CLEAR:   result = io_status_rdata & ~cmd.data;
      OP_ILLEGAL: begin
        result = '0;
        legal  = 1'b0;
      end
      default: begin
        result = '0;
        legal  = 1'b0;
      end
    endcase
    result = result & ~ZERO_FIELD;
  end

  // Reset held during COMMIT suppresses the strobe so an aborted command never lands.
  always_comb begin
    io_wen   = 1'b0;
    io_wdata = 32'h0;
    io_done  = 1'b0;
    io_err   = 1'b0;
    if (state == S_COMMIT && !reset) begin
      io_done = 1'b1;
      if (legal) begin
        io_wen   = 1'b1;
        io_wdata = {8'h00, result};
      end else begin
        io_err   = 1'b1;
      end
    end
  end

endmodule
